// File: rtl/pixel_buf_pkg.sv
// pixel_buf_pkg: shared widths and FSM states for the pixel stream reader.
package pixel_buf_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 48;
  localparam int LANES = 3;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/pixel_out_fifo.sv
// pixel_out_fifo: 2-entry output FIFO with a registered head word.
module pixel_out_fifo #(
  parameter int DATA_W = pixel_buf_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] tail;
  assign valid = count != 2'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      dout <= '0;
      tail <= '0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      // head only moves on a pop or when filling an empty FIFO, so it holds under back-pressure
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) dout <= din;
      else if (pop && count == 2'd2) dout <= tail;
      if (push && ((count == 2'd1 && !pop) || count == 2'd2)) tail <= din;
    end
  end
endmodule

// File: rtl/pixel_stream_reader.sv
// pixel_stream_reader: streams a block of SRAM words out through a ready/valid FIFO.
module pixel_stream_reader #(
  parameter int ADDR_W = pixel_buf_pkg::ADDR_W,
  parameter int DATA_W = pixel_buf_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [ADDR_W-1:0]               length,
  output logic                            busy,
  output logic                            done,
  output logic                            sram_oe,
  output logic [ADDR_W-1:0]               sram_addr,
  output logic [pixel_buf_pkg::LANES-1:0] sram_wen,
  input  logic [DATA_W-1:0]               sram_do,
  output logic                            pix_valid,
  output logic [DATA_W-1:0]               pix_data,
  input  logic                            pix_ready
);
  import pixel_buf_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, rem, last_addr;
  logic inflight, pop, issue;
  logic [1:0] count, level;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign sram_wen = {LANES{1'b1}};
  always_comb begin
    pop = pix_valid & pix_ready;
    // words that will occupy the FIFO once this cycle's pop and pending capture settle
    level = count - {1'b0, pop} + {1'b0, inflight};
    issue = (state == S_READ) && (level < 2'd2);
    sram_oe = issue;
    sram_addr = issue ? addr : last_addr;
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? ((length == '0) ? S_DONE : S_READ) : S_IDLE;
      S_READ:  state_n = (issue && rem == ADDR_W'(1)) ? S_DRAIN : S_READ;
      S_DRAIN: state_n = (count == {1'b0, pop} && !inflight) ? S_DONE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      addr <= '0;
      rem <= '0;
      last_addr <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= issue;
      if (state == S_IDLE && start) begin
        addr <= base_addr;
        rem <= length;
      end else if (issue) begin
        addr <= addr + ADDR_W'(1);
        rem <= rem - ADDR_W'(1);
        last_addr <= addr;
      end
    end
  end
  pixel_out_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .pop  (pop),
    .din  (sram_do),
    .valid(pix_valid),
    .dout (pix_data),
    .count(count)
  );
endmodule

// File: tb/tb_pixel_stream_reader.sv
// tb_pixel_stream_reader: directed checks of streaming, back-pressure, wrap, zero length and reset.
module tb_pixel_stream_reader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_ready = 1'b1;
  logic [9:0] base_addr = '0, length = '0;
  logic busy, done, sram_oe, pix_valid;
  logic [9:0] sram_addr;
  logic [2:0] sram_wen;
  logic [47:0] sram_do = '0, pix_data;
  logic [47:0] mem [1024];
  int vecs = 0, errs = 0;
  logic pv [64], dn [64], oe [64], bz [64], rd [64];
  logic [9:0] ad [64];
  logic [47:0] pd [64];
  logic [47:0] acc [$];
  int acc_c [$], iss_c [$], done_c [$];
  logic [9:0] iss [$];

  pixel_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .sram_oe(sram_oe), .sram_addr(sram_addr), .sram_wen(sram_wen),
    .sram_do(sram_do), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (sram_oe) sram_do <= mem[sram_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // cycle 0 carries start; stall window [lo,hi] drops pix_ready; rst pulsed in cycle rst_at
  task automatic run(input logic [9:0] b, input logic [9:0] l, input int n, input int lo,
                     input int hi, input int rst_at, input int s2_at);
    acc.delete(); acc_c.delete(); iss.delete(); iss_c.delete(); done_c.delete();
    for (int k = 0; k <= n; k++) begin
      @(posedge clk); #1;
      start = (k == 0) || (k == s2_at);
      base_addr = (k == 0) ? b : 10'd100;
      length = (k == 0) ? l : 10'd2;
      rst = (k == rst_at);
      pix_ready = !(k >= lo && k <= hi);
      #3;
      rd[k] = pix_ready; pv[k] = pix_valid; pd[k] = pix_data; dn[k] = done;
      oe[k] = sram_oe; ad[k] = sram_addr; bz[k] = busy;
      if (pv[k] && rd[k]) begin acc.push_back(pd[k]); acc_c.push_back(k); end
      if (oe[k]) begin iss.push_back(ad[k]); iss_c.push_back(k); end
      if (dn[k]) done_c.push_back(k);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0; pix_ready = 1'b1;
  endtask

  initial begin
    int nv;
    for (int i = 0; i < 1024; i++) mem[i] = 48'hC0DE_0000_0000 + 48'(i);
    mem[3] = 48'h1234_5678_9ABC; mem[4] = 48'h1; mem[5] = 48'h2; mem[6] = 48'h3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #3;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_oe", sram_oe, 0);
    chk("rst_valid", pix_valid, 0); chk("rst_addr", sram_addr, 0);
    chk("rst_data", pix_data, 0); chk("rst_wen", sram_wen, 3'b111);

    run(10'd3, 10'd4, 10, 99, 0, -1, -1);
    chk("s1_nacc", acc.size(), 4); chk("s1_niss", iss.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("s1_word", acc[i], mem[3+i]); chk("s1_wcyc", acc_c[i], 3 + i);
      chk("s1_addr", iss[i], 3 + i); chk("s1_icyc", iss_c[i], 1 + i);
    end
    chk("s1_ndone", done_c.size(), 1); chk("s1_dcyc", done_c[0], 7); chk("s1_idle", bz[8], 0);

    run(10'd3, 10'd4, 16, 3, 8, -1, -1);
    nv = 0;
    foreach (iss_c[i]) if (iss_c[i] <= 8) nv++;
    chk("s2_early_iss", nv, 2);
    for (int k = 3; k <= 8; k++) begin
      chk("s2_hold_v", pv[k], 1); chk("s2_hold_d", pd[k], 48'h1234_5678_9ABC);
    end
    chk("s2_nacc", acc.size(), 4);
    for (int i = 0; i < 4; i++) chk("s2_word", acc[i], mem[3+i]);
    chk("s2_ndone", done_c.size(), 1);

    run(10'd1022, 10'd4, 10, 99, 0, -1, -1);
    chk("s3_niss", iss.size(), 4);
    chk("s3_a0", iss[0], 1022); chk("s3_a1", iss[1], 1023); chk("s3_a2", iss[2], 0); chk("s3_a3", iss[3], 1);
    chk("s3_nacc", acc.size(), 4);
    chk("s3_w0", acc[0], mem[1022]); chk("s3_w1", acc[1], mem[1023]);
    chk("s3_w2", acc[2], mem[0]); chk("s3_w3", acc[3], mem[1]);

    run(10'd5, 10'd0, 4, 99, 0, -1, -1);
    nv = 0;
    for (int k = 0; k <= 4; k++) if (pv[k]) nv++;
    chk("s4_ndone", done_c.size(), 1); chk("s4_dcyc", done_c[0], 1);
    chk("s4_niss", iss.size(), 0); chk("s4_nvalid", nv, 0); chk("s4_idle", bz[2], 0);

    run(10'd0, 10'd8, 10, 99, 0, 4, -1);
    nv = 0;
    for (int k = 5; k <= 10; k++) if (pv[k]) nv++;
    chk("s5_busy", bz[5], 0); chk("s5_valid", pv[5], 0);
    chk("s5_nvalid", nv, 0); chk("s5_ndone", done_c.size(), 0);
    run(10'd0, 10'd1, 6, 99, 0, -1, -1);
    chk("s5b_nacc", acc.size(), 1); chk("s5b_word", acc[0], mem[0]);
    chk("s5b_wcyc", acc_c[0], 3); chk("s5b_ndone", done_c.size(), 1); chk("s5b_dcyc", done_c[0], 4);

    run(10'd3, 10'd4, 12, 99, 0, -1, 2);
    chk("s6_ndone", done_c.size(), 1); chk("s6_dcyc", done_c[0], 7);
    chk("s6_niss", iss.size(), 4); chk("s6_nacc", acc.size(), 4);
    for (int i = 0; i < 4; i++) chk("s6_addr", iss[i], 3 + i);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pixel_stream_reader.md
PIXEL_STREAM_READER -- requirements
Module: pixel_stream_reader

Interface
REQ-001 Parameter ADDR_W, default 10, sets the SRAM word-address width (1024 words).
REQ-002 Parameter DATA_W, default 48, sets the pixel word width (3 lanes x 16 bit).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  one-cycle request that latches base_addr and length.
REQ-006 base_addr  input  ADDR_W  first word address to read.
REQ-007 length  input  ADDR_W  number of words to read; 0 is legal.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse when the last word has been accepted downstream.
REQ-010 sram_oe  output  1  read enable to the pixel SRAM read port (OEA).
REQ-011 sram_addr  output  ADDR_W  read address to the pixel SRAM (A).
REQ-012 sram_wen  output  3  lane write enables (WEAN), active-low, tied to 3'b111.
REQ-013 sram_do  input  DATA_W  read data from the pixel SRAM (DOA).
REQ-014 pix_valid  output  1  pix_data holds a valid word.
REQ-015 pix_data  output  DATA_W  pixel word, in address order.
REQ-016 pix_ready  input  1  downstream accept; a transfer occurs when pix_valid and pix_ready are both high at a clock edge.

Function
REQ-017 The FSM SHALL have four states: IDLE, READ, DRAIN and DONE.
REQ-018 IDLE -> READ on start with length != 0; IDLE -> DONE on start with length == 0.
REQ-019 READ -> DRAIN in the cycle after the last read issues; DRAIN -> DONE when the output FIFO is empty and no read is in flight; DONE -> IDLE unconditionally after one cycle.
REQ-020 start SHALL be ignored while busy is high.
REQ-021 A read SHALL issue in cycle N (sram_oe = 1, sram_addr valid) only in READ and only when FIFO occupancy plus in-flight reads is less than 2 after the current cycle's pop.
REQ-022 sram_do for a read issued in cycle N SHALL be captured into the FIFO at the end of cycle N+1.
REQ-023 sram_oe SHALL be 0 in every cycle where no read issues; sram_addr is don't-care there and SHALL be held at its previous value.
REQ-024 Word i SHALL be read from (base_addr + i) mod 2^ADDR_W; the address wraps from 1023 to 0.
REQ-025 The output FIFO SHALL be 2 entries deep, first-in first-out, with registered pix_valid and pix_data.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-027 pix_data SHALL be stable while pix_valid = 1 and pix_ready = 0.
REQ-028 With pix_ready held high, the block SHALL sustain one word per cycle, with the first pix_valid in cycle start+3.
REQ-029 done SHALL assert exactly once per accepted start, including when length == 0 (pulse in cycle start+1).
REQ-030 Arithmetic on the remaining count and the address SHALL be ADDR_W wide; the remaining count is unsigned and SHALL never underflow.

Reset
REQ-031 While rst = 1 at a clock edge, the state SHALL become IDLE and busy, done, sram_oe, pix_valid, FIFO occupancy and the in-flight flag SHALL all become 0.
REQ-032 After reset, sram_addr and pix_data SHALL be 0 and sram_wen SHALL be 3'b111.
REQ-033 A reset during READ or DRAIN SHALL discard in-flight and buffered data; no pix_valid and no done may follow it.

Structure
REQ-034 ADDR_W, DATA_W, LANES = 3 and the state enum SHALL live in the shared package pixel_buf_pkg.
REQ-035 The 2-entry FIFO SHALL be a separate sub-module named pixel_out_fifo.

Verification
REQ-036 Continuous stream: preload words 3..6 = 48'h1234_5678_9ABC, 48'h1, 48'h2, 48'h3 through port B; start with base 3, length 4, pix_ready = 1 -> pix_data sequence 9ABC-word, 1, 2, 3 in cycles start+3..start+6, then done at start+7.
REQ-037 Back-pressure: same stream with pix_ready = 0 for cycles start+3..start+8 -> at most 2 reads issued, pix_data held at 48'h1234_5678_9ABC, no word lost or duplicated afterwards.
REQ-038 Wrap-around: base 1022, length 4 -> sram_addr sequence 1022, 1023, 0, 1.
REQ-039 Zero length: start with length 0 -> done at start+1, sram_oe never asserted, pix_valid never asserted.
REQ-040 Reset mid-run: rst asserted for one cycle at start+4 of a length-8 read -> next cycle busy = 0 and pix_valid = 0, with no done; a following start with base 0, length 1 completes normally.
REQ-041 Start while busy: a second start at start+2 -> ignored, and exactly one done is produced.
